// File: rtl/q_action_select.sv
// rtl/q_action_select.sv - Q-table action selector: 4-way argmax over one Q row, handshaked action offer.
// Optional epsilon-greedy exploration compiled in with `define Q_EXPLORE_EN.
module q_action_select #(
    parameter int          GOAL_STATE = 36,
    parameter int          MAX_STEPS  = 64,
    parameter logic [15:0] EPS_THRESH = 16'h1999,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loop_start,
    input  logic        state_valid,
    input  logic [5:0]  state_in,
    output logic        state_ready,
    output logic        q_rd_en,
    output logic [5:0]  q_rd_state,
    output logic [1:0]  q_rd_action,
    input  logic [31:0] q_rd_data,
    output logic        action_valid,
    output logic [3:0]  action,
    input  logic        action_ready,
    output logic        trial_stop,
    output logic [7:0]  step_count,
    output logic        explore_flag
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, DECIDE, OFFER, STOP} state_t;

    state_t             cur, nxt;
    logic [5:0]         st_lat;
    logic [1:0]         rd_cnt;
    logic               samp_pend;
    logic [1:0]         samp_idx;
    logic signed [31:0] max_val;
    logic [1:0]         max_idx;
    logic [1:0]         act_r;
    logic               expl_r;
    logic [7:0]         step_r;

    logic in_goal, at_limit, illegal_in, end_trial;

    assign in_goal    = (state_in == 6'(GOAL_STATE));
    assign at_limit   = (step_r == 8'(MAX_STEPS));
    assign illegal_in = (state_in == 6'd0) || (state_in > 6'd36);
    assign end_trial  = in_goal || at_limit;

    assign state_ready  = (cur == IDLE);
    assign q_rd_en      = (cur == READ);
    assign q_rd_state   = st_lat;
    assign q_rd_action  = rd_cnt;
    assign action_valid = (cur == OFFER);
    assign action       = {2'b00, act_r};
    assign trial_stop   = (cur == STOP);
    assign step_count   = step_r;
    assign explore_flag = expl_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (state_valid) begin
                    if (end_trial)       nxt = STOP;
                    else if (illegal_in) nxt = OFFER;
                    else                 nxt = READ;
                end
            end
            READ:    if (rd_cnt == 2'd3) nxt = WAIT;
            WAIT:    nxt = DECIDE;
            DECIDE:  nxt = OFFER;
            OFFER:   if (action_ready) nxt = IDLE;
            STOP:    nxt = STOP;
            default: nxt = IDLE;
        endcase
        if (loop_start) nxt = IDLE;
    end

`ifdef Q_EXPLORE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          lfsr <= LFSR_SEED;
        else if (!loop_start && cur == DECIDE) lfsr <= {lfsr[14:0], lfsr_fb};
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EPS_THRESH, LFSR_SEED};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_lat    <= '0;
            rd_cnt    <= '0;
            samp_pend <= 1'b0;
            samp_idx  <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            act_r     <= '0;
            expl_r    <= 1'b0;
            step_r    <= '0;
        end else if (loop_start) begin
            // Abort: drop any in-flight read samples so the next trial starts clean.
            rd_cnt    <= '0;
            samp_pend <= 1'b0;
            samp_idx  <= '0;
            expl_r    <= 1'b0;
            step_r    <= '0;
        end else begin
            samp_pend <= (cur == READ);
            if (cur == IDLE && state_valid) begin
                st_lat   <= state_in;
                rd_cnt   <= '0;
                samp_idx <= '0;
                if (illegal_in && !end_trial) begin
                    act_r  <= '0;
                    expl_r <= 1'b0;
                end
            end
            if (cur == READ) rd_cnt <= rd_cnt + 2'd1;
            // Strictly-greater update keeps the lowest index on ties.
            if (samp_pend) begin
                samp_idx <= samp_idx + 2'd1;
                if (samp_idx == 2'd0 || $signed(q_rd_data) > max_val) begin
                    max_val <= $signed(q_rd_data);
                    max_idx <= samp_idx;
                end
            end
            if (cur == DECIDE) begin
`ifdef Q_EXPLORE_EN
                if (lfsr < EPS_THRESH) begin
                    act_r  <= lfsr[1:0];
                    expl_r <= 1'b1;
                end else begin
                    act_r  <= max_idx;
                    expl_r <= 1'b0;
                end
`else
                act_r  <= max_idx;
                expl_r <= 1'b0;
`endif
            end
            if (cur == OFFER && action_ready && step_r != 8'hFF) step_r <= step_r + 8'd1;
        end
    end

endmodule

// File: doc/q_action_select.md
Q_ACTION_SELECT -- requirements
Module: q_action_select

Interface
REQ-001 SHALL have parameter GOAL_STATE, default 36: maze state that ends a trial.
REQ-002 SHALL have parameter MAX_STEPS, default 64: step limit per trial (8-bit).
REQ-003 SHALL have parameter EPS_THRESH, default 16'h1999: exploration threshold (about 10 %).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- loop_start  in  1  one-cycle pulse that starts a new trial.
- state_valid  in  1  state_in is valid.
- state_in  in  6  current maze state, legal range 1..36.
- state_ready  out  1  block accepts a state.
- q_rd_en  out  1  Q-table read strobe.
- q_rd_state  out  6  Q-table row index.
- q_rd_action  out  2  Q-table column index.
- q_rd_data  in  32  signed Q value; valid in the cycle after q_rd_en.
- action_valid  out  1  action offered.
- action  out  4  chosen action: 0=+6, 1=+1, 2=-6, 3=-1; bits [3:2] are always 0.
- action_ready  in  1  environment accepts the action.
- trial_stop  out  1  trial has ended.
- step_count  out  8  actions issued in the current trial.
- explore_flag  out  1  last action came from exploration.

Function
REQ-006 SHALL implement the FSM states IDLE, READ, WAIT, DECIDE, OFFER and STOP.
REQ-007 SHALL drive state_ready=1 only in IDLE; an accept is state_valid and state_ready both high at a clock edge.
REQ-008 SHALL, on accept, latch state_in and go to STOP if state_in==GOAL_STATE or step_count==MAX_STEPS; otherwise it SHALL go to READ.
REQ-009 SHALL, in READ, spend 4 consecutive cycles asserting q_rd_en, with q_rd_state set to the latched state and q_rd_action = 0, 1, 2, 3 in turn; after those 4 cycles it SHALL go to WAIT.
REQ-010 SHALL sample q_rd_data at the end of the cycle after each q_rd_en; WAIT lasts one cycle and captures the fourth value.
REQ-011 SHALL keep a running signed 32-bit maximum and replace it only on a strictly greater value, so ties resolve to the lowest action index.
REQ-012 SHALL, in DECIDE (one cycle), select the greedy argmax unless exploration applies (REQ-022); the result SHALL be registered into action.
REQ-013 SHALL assert action_valid from the cycle after DECIDE, i.e. the 7th cycle after the accept cycle with a zero-latency read port.
REQ-014 SHALL hold action and action_valid stable until action_ready is sampled high.
REQ-015 SHALL, on the action handshake, increment step_count, saturating at 255, and return to IDLE.
REQ-016 SHALL, in STOP, hold trial_stop=1, action_valid=0 and state_ready=0 until loop_start.
REQ-017 SHALL treat loop_start as highest priority in any state:
- next state is IDLE;
- step_count=0, trial_stop=0, action_valid=0, explore_flag=0;
- the running maximum is discarded;
- a simultaneous action handshake is not counted.
REQ-018 SHALL treat state_in of 0 or greater than 36 as an illegal state: it is accepted, no Q read is issued, and action 0 is offered with explore_flag=0.

Reset
REQ-019 SHALL, while rst=0, asynchronously set: FSM=IDLE, state_ready=1, q_rd_en=0, q_rd_state=0, q_rd_action=0, action_valid=0, action=0, trial_stop=0, step_count=0, explore_flag=0, LFSR=LFSR_SEED.
REQ-020 SHALL release reset synchronously to clk; the first accept is possible on the first edge after release.

Configuration
REQ-021 SHALL compile epsilon-greedy exploration in only when macro Q_EXPLORE_EN is defined.
REQ-022 SHALL, with Q_EXPLORE_EN defined:
- keep a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11, advanced once per DECIDE;
- in DECIDE, if the pre-advance LFSR value < EPS_THRESH, set action = LFSR[1:0] and explore_flag=1;
- otherwise set action to the argmax and explore_flag=0.
REQ-023 SHALL, without Q_EXPLORE_EN, always select the argmax, tie explore_flag to 0, and contain no LFSR logic.

Verification
REQ-024 Greedy choice: state 8, Q row {5, -3, 12, 12}, EPS_THRESH=0 -> action=2 on the 7th cycle after accept, step_count goes 0->1 on handshake.
REQ-025 Backpressure: action_ready held low for 10 cycles, then high -> action and action_valid stable throughout, exactly one step_count increment.
REQ-026 Goal and limit: state 36 accepted -> STOP, trial_stop=1, no q_rd_en; separately, after MAX_STEPS=3 handshakes, the next accept -> trial_stop=1.
REQ-027 Abort: loop_start pulsed during READ cycle 2 -> next cycle IDLE, q_rd_en=0, step_count=0, state_ready=1.
REQ-028 Exploration (Q_EXPLORE_EN): LFSR_SEED=16'h0003, EPS_THRESH=16'hFFFF -> first action=3, explore_flag=1; the same test without the macro -> argmax, explore_flag=0.
REQ-029 Reset mid-OFFER: rst=0 while action_valid=1 -> all outputs reach the REQ-019 values immediately, without waiting for a clock edge.
